// File: rtl/wb_display_scroll_if.sv
// rtl/wb_display_scroll_if.sv - Wishbone bus bundle for the display scroll sequencer
interface wb_display_scroll_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_display_scroll.sv
// rtl/wb_display_scroll.sv - Wishbone scroll sequencer stepping an 8-byte message over the display
module wb_display_scroll (
  input  logic                      clk,
  input  logic                      reset,
  wb_display_scroll_if.slave        wb,
  output logic [7:0]                disp_m,
  output logic [7:0]                disp_l
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic        ack;
  logic        ctrl_run;
  logic        ctrl_oneshot;
  logic        done;
  logic [23:0] period;
  logic [23:0] counter;
  logic [2:0]  len;
  logic [2:0]  idx;
  logic [7:0]  msg [8];
  logic [31:0] dat_o;

  logic        rd;
  logic        wr;
  logic        ctrl_wr;
  logic        len_wr;
  logic [2:0]  reg_sel;
  logic [31:0] rdata;
  logic [2:0]  idx_inc;
  logic [2:0]  idx_after;
  logic [2:0]  idx_next;
  logic        step;
  logic        to_done;
  logic [40:0] unused_bits;

  assign reg_sel     = wb.wb_adr_i[4:2];
  assign rd          = wb.wb_stb_i & wb.wb_cyc_i & ~ack & ~wb.wb_we_i;
  assign wr          = wb.wb_stb_i & wb.wb_cyc_i & ~ack &  wb.wb_we_i;
  assign ctrl_wr     = wr && (reg_sel == 3'd0);
  assign len_wr      = wr && (reg_sel == 3'd3);
  assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack;
  assign wb.wb_dat_o = dat_o;
  assign unused_bits = {wb.wb_sel_i, wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_dat_i[31:24]};

  // A CTRL write on a step edge suppresses the step; a LEN write is checked
  // against the idx that results after any step on the same edge.
  always_comb begin
    idx_inc   = (idx == len) ? 3'd0 : idx + 3'd1;
    step      = (state == RUN) && (counter == 24'd0) && !ctrl_wr;
    to_done   = step && (idx == len) && ctrl_oneshot;
    idx_after = idx;
    if (ctrl_wr) begin
      if (wb.wb_dat_i[2] || (state == DONE && wb.wb_dat_i[0]))
        idx_after = 3'd0;
    end else if (step && !to_done) begin
      idx_after = idx_inc;
    end
    idx_next = idx_after;
    if (len_wr && (wb.wb_dat_i[2:0] < idx_after))
      idx_next = 3'd0;
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      3'd0:    rdata = {30'd0, ctrl_oneshot, ctrl_run};
      3'd1:    rdata = {25'd0, idx, 2'b00, done, state == RUN};
      3'd2:    rdata = {8'd0, period};
      3'd3:    rdata = {29'd0, len};
      default: rdata = {16'd0, msg[{reg_sel[1:0], 1'b0}], msg[{reg_sel[1:0], 1'b1}]};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ack          <= 1'b0;
      ctrl_run     <= 1'b0;
      ctrl_oneshot <= 1'b0;
      done         <= 1'b0;
      period       <= 24'd0;
      counter      <= 24'd0;
      len          <= 3'd0;
      idx          <= 3'd0;
      dat_o        <= 32'd0;
      disp_m       <= 8'h00;
      disp_l       <= 8'h00;
      for (int i = 0; i < 8; i++)
        msg[i] <= 8'h00;
    end else begin
      ack    <= rd | wr;
      idx    <= idx_next;
      disp_m <= msg[idx];
      disp_l <= msg[idx_inc];
      if (rd)
        dat_o <= rdata;

      if (wr) begin
        case (reg_sel)
          3'd2: period <= wb.wb_dat_i[23:0];
          3'd3: len    <= wb.wb_dat_i[2:0];
          3'd4, 3'd5, 3'd6, 3'd7: begin
            msg[{reg_sel[1:0], 1'b0}] <= wb.wb_dat_i[15:8];
            msg[{reg_sel[1:0], 1'b1}] <= wb.wb_dat_i[7:0];
          end
          default: ;
        endcase
      end

      if (ctrl_wr) begin
        ctrl_run     <= wb.wb_dat_i[0];
        ctrl_oneshot <= wb.wb_dat_i[1];
        if (wb.wb_dat_i[2]) begin
          done    <= 1'b0;
          counter <= period;
          state   <= wb.wb_dat_i[0] ? RUN : IDLE;
        end else if (wb.wb_dat_i[0]) begin
          // Already running: keep the tick cadence, only the step is lost.
          if (state != RUN)
            counter <= period;
          else
            counter <= (counter == 24'd0) ? period : counter - 24'd1;
          if (state == DONE)
            done <= 1'b0;
          state <= RUN;
        end else if (state == RUN) begin
          state <= IDLE;
        end
      end else if (state == RUN) begin
        if (counter == 24'd0) begin
          counter <= period;
          if (to_done) begin
            state    <= DONE;
            done     <= 1'b1;
            ctrl_run <= 1'b0;
          end
        end else begin
          counter <= counter - 24'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_display_scroll.sv
// tb/tb_wb_display_scroll.sv - directed self-checking bench for wb_display_scroll
module tb_wb_display_scroll;

  logic       clk;
  logic       reset;
  logic [7:0] disp_m;
  logic [7:0] disp_l;
  int         passed;
  int         total;

  wb_display_scroll_if bus ();

  wb_display_scroll dut (
    .clk    (clk),
    .reset  (reset),
    .wb     (bus),
    .disp_m (disp_m),
    .disp_l (disp_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    bus.wb_adr_i = a;
    bus.wb_dat_i = d;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.wb_ack_o !== 1'b1 && n < 4);
    if (bus.wb_ack_o !== 1'b1) begin
      total++;
      $display("FAIL write_ack_timeout: adr %h got ack %b expected 1", a, bus.wb_ack_o);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    @(posedge clk); #1;
    bus.wb_adr_i = a;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.wb_ack_o !== 1'b1 && n < 4);
    d = bus.wb_dat_o;
    if (bus.wb_ack_o !== 1'b1) begin
      total++;
      $display("FAIL read_ack_timeout: adr %h got ack %b expected 1", a, bus.wb_ack_o);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({disp_m, disp_l, bus.wb_ack_o} !== 17'h0) $display("FAIL reset_outputs: got %h expected 0", {disp_m, disp_l, bus.wb_ack_o});
    else passed++;
    total++;
    if (bus.wb_dat_o !== 32'h0) $display("FAIL reset_dat_o: got %h expected 0", bus.wb_dat_o);
    else passed++;
    reset = 1'b1;
    for (int a = 0; a < 8; a++) begin
      wb_read(a * 4, d);
      total++;
      if (d !== 32'h0) $display("FAIL reset_read_%0d: got %h expected 00000000", a, d);
      else passed++;
    end
  endtask

  task automatic test_registers();
    logic [31:0] d;
    wb_write(32'h08, 32'hAB12_3456);
    wb_read(32'h08, d);
    total++;
    if (d !== 32'h0012_3456) $display("FAIL period_readback: got %h expected 00123456", d);
    else passed++;
    wb_write(32'h0C, 32'hFFFF_FFFA);
    wb_read(32'h0C, d);
    total++;
    if (d !== 32'h0000_0002) $display("FAIL len_readback: got %h expected 00000002", d);
    else passed++;
    wb_write(32'h00, 32'h0000_0006);
    wb_read(32'h00, d);
    total++;
    if (d !== 32'h0000_0002) $display("FAIL ctrl_restart_reads_zero: got %h expected 00000002", d);
    else passed++;
    wb_read(32'h04, d);
    total++;
    if (d !== 32'h0) $display("FAIL status_idle: got %h expected 00000000", d);
    else passed++;
    wb_write(32'h00, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] acks;
    @(posedge clk); #1;
    bus.wb_adr_i = 32'h08;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      acks[i] = bus.wb_ack_o;
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    total++;
    if (acks !== 3'b101) $display("FAIL held_strobe_ack_pattern: got %b expected 101", acks);
    else passed++;
  endtask

  task automatic load_message();
    wb_write(32'h10, 32'h3F06);
    wb_write(32'h14, 32'h5B4F);
    wb_write(32'h18, 32'h6D7D);
    wb_write(32'h1C, 32'h0777);
  endtask

  task automatic test_continuous();
    logic [15:0] exp_seq [5];
    exp_seq = '{16'h3F06, 16'h065B, 16'h5B4F, 16'h4F3F, 16'h3F06};
    wb_write(32'h00, 32'h4);
    wb_write(32'h0C, 32'h3);
    wb_write(32'h08, 32'h4);
    wb_write(32'h00, 32'h1);
    total++;
    if ({disp_m, disp_l} !== exp_seq[0]) $display("FAIL scroll_start: got %h expected %h", {disp_m, disp_l}, exp_seq[0]);
    else passed++;
    for (int k = 1; k < 5; k++) begin
      repeat ((k == 1) ? 5 : 4) @(posedge clk);
      #1;
      total++;
      if ({disp_m, disp_l} !== exp_seq[k-1]) $display("FAIL scroll_hold_%0d: got %h expected %h", k, {disp_m, disp_l}, exp_seq[k-1]);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({disp_m, disp_l} !== exp_seq[k]) $display("FAIL scroll_step_%0d: got %h expected %h", k, {disp_m, disp_l}, exp_seq[k]);
      else passed++;
    end
    wb_write(32'h00, 32'h4);
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wb_write(32'h00, 32'h3);
    repeat (17) @(posedge clk);
    wb_read(32'h04, d);
    total++;
    if (d !== 32'h31) $display("FAIL oneshot_idx3_busy: got %h expected 00000031", d);
    else passed++;
    repeat (5) @(posedge clk);
    wb_read(32'h04, d);
    total++;
    if (d !== 32'h32) $display("FAIL oneshot_done_status: got %h expected 00000032", d);
    else passed++;
    wb_read(32'h00, d);
    total++;
    if (d !== 32'h2) $display("FAIL oneshot_run_cleared: got %h expected 00000002", d);
    else passed++;
    repeat (12) @(posedge clk);
    #1;
    total++;
    if ({disp_m, disp_l} !== 16'h4F3F) $display("FAIL oneshot_hold: got %h expected 4f3f", {disp_m, disp_l});
    else passed++;
    wb_write(32'h00, 32'h4);
  endtask

  task automatic test_restart_collision();
    wb_write(32'h08, 32'h9);
    wb_write(32'h00, 32'h1);
    repeat (8) @(posedge clk);
    wb_write(32'h00, 32'h5);
    @(posedge clk); #1;
    total++;
    if ({disp_m, disp_l} !== 16'h3F06) $display("FAIL collision_step_suppressed: got %h expected 3f06", {disp_m, disp_l});
    else passed++;
    repeat (9) @(posedge clk);
    #1;
    total++;
    if ({disp_m, disp_l} !== 16'h3F06) $display("FAIL collision_no_early_step: got %h expected 3f06", {disp_m, disp_l});
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({disp_m, disp_l} !== 16'h065B) $display("FAIL collision_step_after_10: got %h expected 065b", {disp_m, disp_l});
    else passed++;
    wb_write(32'h00, 32'h4);
  endtask

  task automatic test_len_shrink();
    logic [15:0] exp_seq [6];
    exp_seq = '{16'h3F06, 16'h065B, 16'h065B, 16'h5B3F, 16'h5B3F, 16'h3F06};
    wb_write(32'h0C, 32'h7);
    wb_write(32'h08, 32'h1);
    wb_write(32'h00, 32'h1);
    repeat (11) @(posedge clk);
    wb_write(32'h0C, 32'h2);
    total++;
    if ({disp_m, disp_l} !== 16'h0777) $display("FAIL shrink_at_idx6: got %h expected 0777", {disp_m, disp_l});
    else passed++;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      total++;
      if ({disp_m, disp_l} !== exp_seq[k]) $display("FAIL shrink_seq_%0d: got %h expected %h", k, {disp_m, disp_l}, exp_seq[k]);
      else passed++;
    end
    wb_write(32'h00, 32'h4);
  endtask

  task automatic test_wrap();
    wb_write(32'h0C, 32'h7);
    wb_write(32'h00, 32'h1);
    repeat (14) @(posedge clk);
    @(posedge clk); #1;
    total++;
    if ({disp_m, disp_l} !== 16'h773F) $display("FAIL wrap_len7: got %h expected 773f", {disp_m, disp_l});
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({disp_m, disp_l} !== 16'h3F06) $display("FAIL wrap_to_zero: got %h expected 3f06", {disp_m, disp_l});
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    @(posedge clk); #1;
    bus.wb_adr_i = 32'h04;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.wb_ack_o !== 1'b1 || {disp_m, disp_l} === 16'h0) $display("FAIL pre_reset_active: got ack %b disp %h expected ack 1 disp nonzero", bus.wb_ack_o, {disp_m, disp_l});
    else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.wb_ack_o, disp_m, disp_l} !== 17'h0) $display("FAIL async_reset_immediate: got %h expected 0", {bus.wb_ack_o, disp_m, disp_l});
    else passed++;
    total++;
    if (bus.wb_dat_o !== 32'h0) $display("FAIL async_reset_dat_o: got %h expected 0", bus.wb_dat_o);
    else passed++;
    reset = 1'b1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    wb_write(32'h10, 32'h3F06);
    repeat (10) @(posedge clk);
    wb_read(32'h04, d);
    total++;
    if (d !== 32'h0) $display("FAIL post_reset_status: got %h expected 00000000", d);
    else passed++;
    wb_read(32'h00, d);
    total++;
    if (d !== 32'h0) $display("FAIL post_reset_ctrl: got %h expected 00000000", d);
    else passed++;
    wb_read(32'h18, d);
    total++;
    if (d !== 32'h0) $display("FAIL post_reset_msg2: got %h expected 00000000", d);
    else passed++;
    total++;
    if ({disp_m, disp_l} !== 16'h3F3F) $display("FAIL post_reset_no_scroll: got %h expected 3f3f", {disp_m, disp_l});
    else passed++;
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    reset        = 1'b0;
    bus.wb_adr_i = 32'h0;
    bus.wb_dat_i = 32'h0;
    bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    test_reset();
    test_registers();
    test_back_to_back();
    load_message();
    test_continuous();
    test_oneshot();
    test_restart_collision();
    test_len_shrink();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_display_scroll.md
# wb_display_scroll

Wishbone-slave scroll sequencer for the 4-digit seven-segment display. Holds an 8-byte message buffer and, on a programmable tick, steps a window index through it, driving the two display bytes (MSB pair / LSB pair) that feed the display engine. Software loads text once and starts the engine; it scrolls continuously or runs one pass and stops.

## Interface
- No parameters; buffer depth is fixed at 8 bytes and the prescaler at 24 bits.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wb_adr_i  in  32  word address; bits [4:2] decoded
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  registered read data
- wb_sel_i  in  4  ignored; all writes are full-word
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone cycle, strobe and write enable
- wb_ack_o  out  1  equals wb_stb_i & wb_cyc_i & ack
- disp_m  out  8  byte for the display MSB pair: msg[idx]
- disp_l  out  8  byte for the display LSB pair: msg[(idx+1) mod (len+1)]

## Operation
- Register map, wb_adr_i[4:2]:
  - 0 CTRL (rw): bit0 run, bit1 oneshot, bit2 restart. Restart is write-only and self-clearing; it reads 0.
  - 1 STATUS (ro): bit0 busy (state RUN), bit1 done, [6:4] idx. All other bits read 0.
  - 2 PERIOD (rw): [23:0]. A step occurs every PERIOD+1 clk cycles.
  - 3 LEN (rw): [2:0] = message length − 1.
  - 4..7 MSG (rw): word k holds msg[2(k−4)] in [15:8] and msg[2(k−4)+1] in [7:0].
- Bus handshake:
  - rd = stb&cyc&~ack&~we; wr = stb&cyc&~ack&we.
  - Either one sets ack for exactly one cycle. Back-to-back accesses therefore need ack to fall for one cycle in between.
  - The read mux and register updates occur on the same edge that sets ack.
- FSM states: IDLE, RUN, DONE.
  - IDLE: counter holds. A CTRL write with run=1 goes to RUN and loads counter = PERIOD.
  - RUN: counter decrements; at 0 it reloads PERIOD and steps.
    - Step rule: if idx==len and oneshot=1, go to DONE, set done=1 and clear the run bit. Otherwise idx = (idx==len) ? 0 : idx+1.
    - A CTRL write with run=0 goes to IDLE; idx is held.
  - DONE: idx holds at len. A CTRL write with run=1 goes to RUN, sets idx=0 and clears done.
- Restart=1 in any CTRL write: idx=0, counter=PERIOD, done=0. The state then follows the written run bit.
- A LEN write with new len < idx forces idx=0 on the same edge. A PERIOD write takes effect at the next reload.
- disp_m and disp_l are registered every cycle from the current idx, len and buffer. MSG writes are therefore visible on the outputs one cycle after the write edge.

## Timing
- Reset values: wb_dat_o, ack, disp_m, disp_l, idx, counter, PERIOD, LEN and CTRL are all 0; all buffer bytes are 0x00; state is IDLE.
- Reset asserted mid-operation returns everything to these values immediately (asynchronous), including a pending ack.
- Ack latency: 1 cycle after stb&cyc is sampled; read data is valid in the same cycle ack is high.
- Step edge to output change: 1 cycle (idx updates on the step edge; disp_* update on the next edge).
- Simultaneous events:
  - A CTRL write on a step edge wins; the step is discarded.
  - A LEN write on a step edge: the step applies first, then the len<idx check runs against the new idx.
- With PERIOD=0, a step occurs every cycle while in RUN.
- Wrap: after idx==len, the next step gives idx=0. With len=7, the disp_l index wraps from 7 to 0.

## Test plan
- Reset then read: release reset, read addresses 0..7 -> all return 0x0000_0000; disp_m=disp_l=0x00; ack high for exactly 1 cycle per access.
- Continuous scroll: MSG0=0x3F06, MSG1=0x5B4F, LEN=3, PERIOD=4, CTRL=0x1.
  - Required: steps every 5 cycles; disp_m/disp_l sequence 3F/06, 06/5B, 5B/4F, 4F/3F, then back to 3F/06.
- Oneshot: same data, CTRL=0x3.
  - Required: after 3 steps idx=3; at the 4th tick STATUS=0x32 (done, idx=3, not busy); CTRL bit0 reads 0; outputs hold 4F/3F.
- Restart collision: RUN with PERIOD=9; write CTRL=0x5 on a step edge.
  - Required: idx=0, the step is suppressed, and the next step occurs 10 cycles later.
- LEN shrink: RUN with LEN=7 and idx=6; write LEN=2.
  - Required: idx=0 on that edge; scroll then cycles over idx 0..2 only.
- Async reset mid-run: assert reset for 1 ns between clock edges during RUN.
  - Required: outputs, idx and state immediately return to reset values; there is no scrolling after release until CTRL is written.
